// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/8-data/parity/stop serialiser on clk_baud.
// Latency: byte pushed at edge N into an empty FIFO while idle and enabled drives the start bit at edge N+1.
// Backpressure: data_ready = FIFO not full (registered count); frames start only while tx_rx_start is high.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_baud,
    input  logic                          rst_n,
    input  logic                          tx_rx_start,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    current_state_tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        SEND   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [1:0]       r_stop_cnt;
    logic             r_parity;
    logic             r_tx;
    logic             r_done;

    logic             w_push;
    logic             w_pop;
    logic             w_can_pop;
    logic [7:0]       w_head;
    logic             w_head_par;
    state_t           w_state_nxt;
    logic [7:0]       w_shift_nxt;
    logic [3:0]       w_bit_cnt_nxt;
    logic [1:0]       w_stop_cnt_nxt;
    logic             w_parity_nxt;
    logic             w_tx_nxt;
    logic             w_done_nxt;

    assign data_ready       = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push           = data_valid && data_ready;
    assign w_can_pop        = tx_rx_start && (r_count != '0);
    assign w_head           = r_mem[r_rd_ptr];
    assign w_head_par       = (^w_head) ^ (PARITY_ODD != 0);

    assign tx               = r_tx;
    assign tx_busy          = (r_state != IDLE);
    assign tx_done          = r_done;
    assign fifo_count       = r_count;
    assign current_state_tx = r_state;

    always_ff @(posedge clk_baud) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_baud or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_baud or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_can_pop) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_parity_nxt  = w_head_par;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                    w_state_nxt   = START;
                end
            end
            START: begin
                w_tx_nxt      = r_shift[0];
                w_shift_nxt   = {1'b0, r_shift[7:1]};
                w_bit_cnt_nxt = 4'd1;
                w_state_nxt   = SEND;
            end
            SEND: begin
                // r_bit_cnt counts data bits already placed on the line
                if (r_bit_cnt == 4'd8) begin
                    w_tx_nxt    = r_parity;
                    w_state_nxt = PARITY;
                end else begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                end
            end
            PARITY: begin
                w_tx_nxt       = 1'b1;
                w_stop_cnt_nxt = 2'd1;
                w_state_nxt    = STOP;
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (r_stop_cnt >= 2'(STOP_BITS)) begin
                    w_done_nxt = 1'b1;
                    if (w_can_pop) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_head;
                        w_parity_nxt  = w_head_par;
                        w_bit_cnt_nxt = '0;
                        w_tx_nxt      = 1'b0;
                        w_state_nxt   = START;
                    end else begin
                        w_state_nxt   = IDLE;
                    end
                end else begin
                    w_stop_cnt_nxt = r_stop_cnt + 2'd1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
